// File: rtl/iob_axi_burst_master.sv
// iob_axi_burst_master: splits one native transfer command into 4 KB-safe AXI4 INCR bursts with a word-stream user side
module iob_axi_burst_master #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 1,
  parameter int MAX_LEN = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [15:0]         cmd_len,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic [3:0]          m_axi_arqos,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, nxt_addr, cmd_base;
  logic [15:0] rem_q, rem_d, nxt_rem;
  logic [8:0] len_q, len_d, cnt_q, cnt_d, len_m1;
  logic dir_q, dir_d, err_q, err_d;
  logic wr_phase, rd_phase, w_hs, r_hs, last_beat, unused_ids;
  function automatic logic [8:0] beats(input logic [9:0] word, input logic [15:0] rem);
    logic [15:0] room, b;
    room = 16'd1024 - {6'd0, word};
    b = rem > 16'(MAX_LEN) ? 16'(MAX_LEN) : rem;
    return b > room ? room[8:0] : b[8:0];
  endfunction
  assign unused_ids = ^{m_axi_bid, m_axi_rid};
  assign cmd_base = {cmd_addr[ADDR_W-1:2], 2'b00};
  assign nxt_addr = addr_q + ADDR_W'({len_q, 2'b00});
  assign nxt_rem = rem_q - 16'(len_q);
  assign len_m1 = len_q - 9'd1;
  assign wr_phase = state_q == DATA && dir_q;
  assign rd_phase = state_q == DATA && !dir_q;
  assign w_hs = wr_phase && wr_valid && m_axi_wready;
  assign r_hs = rd_phase && m_axi_rvalid && rd_ready;
  assign last_beat = cnt_q == 9'd1;
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err = err_q;
  assign m_axi_awid = '0;
  assign m_axi_awaddr = addr_q;
  assign m_axi_awlen = len_m1[7:0];
  assign m_axi_awsize = 3'd2;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot = 3'd0;
  assign m_axi_awqos = 4'd0;
  assign m_axi_awvalid = state_q == ADDR && dir_q;
  assign m_axi_arid = '0;
  assign m_axi_araddr = addr_q;
  assign m_axi_arlen = len_m1[7:0];
  assign m_axi_arsize = 3'd2;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot = 3'd0;
  assign m_axi_arqos = 4'd0;
  assign m_axi_arvalid = state_q == ADDR && !dir_q;
  assign m_axi_wdata = wr_data;
  assign m_axi_wstrb = '1;
  assign m_axi_wvalid = wr_phase && wr_valid;
  assign m_axi_wlast = wr_phase && last_beat;
  assign wr_ready = wr_phase && m_axi_wready;
  assign m_axi_bready = state_q == RESP;
  assign rd_valid = rd_phase && m_axi_rvalid;
  assign rd_data = m_axi_rdata;
  assign m_axi_rready = rd_phase && rd_ready;
  // next-state: command latch, burst sizing, beat counting and error capture
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    len_d = len_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d = cmd_base;
        rem_d = cmd_len;
        dir_d = cmd_dir;
        err_d = 1'b0;
        len_d = beats(cmd_base[11:2], cmd_len);
        state_d = cmd_len == 16'd0 ? DONE : ADDR;
      end
      ADDR: if (dir_q ? m_axi_awready : m_axi_arready) begin
        cnt_d = len_q;
        state_d = DATA;
      end
      DATA: if (w_hs || r_hs) begin
        cnt_d = cnt_q - 9'd1;
        err_d = err_q | (r_hs && (m_axi_rresp != 2'b00 || m_axi_rlast != last_beat));
        if (last_beat && dir_q) state_d = RESP;
        else if (last_beat) begin
          addr_d = nxt_addr;
          rem_d = nxt_rem;
          len_d = beats(nxt_addr[11:2], nxt_rem);
          state_d = nxt_rem == 16'd0 ? DONE : ADDR;
        end
      end
      RESP: if (m_axi_bvalid) begin
        err_d = err_q | (m_axi_bresp != 2'b00);
        addr_d = nxt_addr;
        rem_d = nxt_rem;
        len_d = beats(nxt_addr[11:2], nxt_rem);
        state_d = nxt_rem == 16'd0 ? DONE : ADDR;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and burst registers; every AXI control output decodes from these
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      dir_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      err_q <= err_d;
    end
  end
endmodule
